window3x3_gen: RTL

- Raster-scan pixel stream in; complete 3x3 neighbourhood out, one window per interior pixel.
- Outputs w0..w8 connect 1:1 to the inputs in0..in8 of the 3x3 mean stage that follows it in the dehazing pipeline.
- Two internal line buffers hold the previous two rows.
- Valid-qualified streaming, no backpressure; frame framing via start-of-frame in and end-of-frame out.

---
 rtl/window3x3_gen_if.sv | 39 +++
 rtl/window3x3_gen.sv | 120 ++++++++++++
 2 files changed

// File: rtl/window3x3_gen_if.sv
// window3x3_gen_if -- stream bus between a raster pixel source and the
// 3x3 window generator.
//   i_valid/i_sof/i_pixel : raster pixel stream toward the generator
//   o_valid/o_eof         : window strobe and last-window-of-frame flag
//   o_w0..o_w8            : 3x3 window, row-major, o_w4 = centre
//   o_row/o_col           : window centre coordinate (WIN3X3_COORD_EN only)
// Modports: master = pixel source / window sink, slave = the generator.
interface window3x3_gen_if #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int DATA_W     = 8
);
   logic              i_valid;
   logic              i_sof;
   logic [DATA_W-1:0] i_pixel;
   logic              o_valid;
   logic              o_eof;
   logic [DATA_W-1:0] o_w0, o_w1, o_w2, o_w3, o_w4, o_w5, o_w6, o_w7, o_w8;
`ifdef WIN3X3_COORD_EN
   logic [$clog2(IMG_HEIGHT)-1:0] o_row;
   logic [$clog2(IMG_WIDTH)-1:0]  o_col;
`endif

   modport master (
      output i_valid, i_sof, i_pixel,
      input  o_valid, o_eof, o_w0, o_w1, o_w2, o_w3, o_w4, o_w5, o_w6, o_w7, o_w8
`ifdef WIN3X3_COORD_EN
      , input o_row, o_col
`endif
   );

   modport slave (
      input  i_valid, i_sof, i_pixel,
      output o_valid, o_eof, o_w0, o_w1, o_w2, o_w3, o_w4, o_w5, o_w6, o_w7, o_w8
`ifdef WIN3X3_COORD_EN
      , output o_row, o_col
`endif
   );
endinterface

// File: rtl/window3x3_gen.sv
// window3x3_gen -- raster-scan pixel stream in, full 3x3 neighbourhood out,
// one window per interior pixel (no border windows).
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : window3x3_gen_if.slave (pixel stream in, window stream out)
// Two line buffers hold the previous two rows; a two-column shift window
// plus the freshly read column form the 3x3 output, registered (1 clk).
// Optional feature: define WIN3X3_COORD_EN to drive o_row/o_col with the
// centre coordinate of each emitted window.
module window3x3_gen #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int DATA_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   window3x3_gen_if.slave   bus
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t                    state;
   logic [CW-1:0]             col;
   logic [RW-1:0]             row;
   logic [DATA_W-1:0]         buf0 [IMG_WIDTH];   // row r-1 relative to input
   logic [DATA_W-1:0]         buf1 [IMG_WIDTH];   // row r-2 relative to input
   // shift window columns, index 0 = top, 1 = middle, 2 = bottom
   logic [2:0][DATA_W-1:0]    cola, colb;

   logic                      start, adv, acc, emit, last_col, last_row;
   logic [CW-1:0]             acol;
   logic [RW-1:0]             arow;
   logic [DATA_W-1:0]         b0, b1;
   logic [2:0][DATA_W-1:0]    newcol;

   // A start-of-frame pixel is always taken as (0,0), whatever the state;
   // this is also how a mid-frame i_sof aborts the running frame.
   always_comb begin
      start    = bus.i_valid & bus.i_sof;
      adv      = bus.i_valid & ~bus.i_sof & (state == ACTIVE);
      acc      = start | adv;
      acol     = start ? '0 : col;
      arow     = start ? '0 : row;
      b0       = buf0[acol];
      b1       = buf1[acol];
      newcol   = {bus.i_pixel, b0, b1};
      last_col = (acol == CW'(IMG_WIDTH - 1));
      last_row = (arow == RW'(IMG_HEIGHT - 1));
      // Columns 0/1 only prime the shift window, so the stale columns left
      // over from the previous row never reach an emitted window.
      emit     = acc & (arow >= RW'(2)) & (acol >= CW'(2));
   end

   // Line buffers: no reset, contents are rewritten before they are used.
   always_ff @(posedge clk) begin
      if (acc) begin
         buf1[acol] <= b0;
         buf0[acol] <= bus.i_pixel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         cola        <= '0;
         colb        <= '0;
         bus.o_valid <= 1'b0;
         bus.o_eof   <= 1'b0;
         bus.o_w0    <= '0;
         bus.o_w1    <= '0;
         bus.o_w2    <= '0;
         bus.o_w3    <= '0;
         bus.o_w4    <= '0;
         bus.o_w5    <= '0;
         bus.o_w6    <= '0;
         bus.o_w7    <= '0;
         bus.o_w8    <= '0;
`ifdef WIN3X3_COORD_EN
         bus.o_row   <= '0;
         bus.o_col   <= '0;
`endif
      end else begin
         bus.o_valid <= emit;
         bus.o_eof   <= emit & last_row & last_col;
         if (acc) begin
            cola <= colb;
            colb <= newcol;
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : arow + RW'(1);
            end else begin
               col <= acol + CW'(1);
               row <= arow;
            end
            state <= (last_row & last_col) ? DONE : ACTIVE;
         end
         // Accepting (r+1,c+1): cola = column c-1, colb = column c,
         // the read-out column is c+1.
         if (emit) begin
            bus.o_w0 <= cola[0];
            bus.o_w1 <= colb[0];
            bus.o_w2 <= b1;
            bus.o_w3 <= cola[1];
            bus.o_w4 <= colb[1];
            bus.o_w5 <= b0;
            bus.o_w6 <= cola[2];
            bus.o_w7 <= colb[2];
            bus.o_w8 <= bus.i_pixel;
`ifdef WIN3X3_COORD_EN
            bus.o_row <= arow - RW'(1);
            bus.o_col <= acol - CW'(1);
`endif
         end
      end
   end
endmodule
